// File: rtl/delay_line_ctrl_pkg.sv
// Shared types for the circular audio delay-line controller.
package delay_line_ctrl_pkg;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_READ_ENC = 2'd1;
  localparam logic [1:0] ST_OUT_ENC  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE_ENC,
    READ = ST_READ_ENC,
    OUT  = ST_OUT_ENC
  } state_t;

endpackage

// File: rtl/delay_line_ctrl.sv
// Sequences an external dual-port BRAM as a circular delay line: one sample
// written per input handshake, the sample written `delay` samples earlier
// returned on a valid/ready output. Unfilled history reads back as zero.
module delay_line_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_sample,
  input  logic [ADDR_WIDTH-1:0] delay,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_sample,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [ADDR_WIDTH-1:0] ram_dpra,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_dpo
);

  import delay_line_ctrl_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] FILL_MAX = '1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] fill_q, fill_d;
  logic [ADDR_WIDTH-1:0] d_q, d_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_sample_q, out_sample_d;

  // State and datapath registers; synchronous reset drops any pending output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      d_q          <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      d_q          <= d_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
    end
  end

  // Next-state logic and BRAM port drive; write and read address share an edge.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    d_d          = d_q;
    out_valid_d  = out_valid_q;
    out_sample_d = out_sample_q;
    in_ready     = 1'b0;
    ram_we       = 1'b0;
    ram_a        = wr_ptr_q;
    ram_di       = in_sample;
    ram_dpra     = ADDR_WIDTH'(wr_ptr_q - d_q);

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        ram_dpra = ADDR_WIDTH'(wr_ptr_q - delay);
        if (in_valid) begin
          ram_we  = 1'b1;
          d_d     = delay;
          state_d = READ;
        end
      end
      READ: begin
        // Delay reaching past what has been written since reset reads as silence.
        out_sample_d = (d_q > fill_q) ? '0 : ram_dpo;
        out_valid_d  = 1'b1;
        wr_ptr_d     = ADDR_WIDTH'(wr_ptr_q + 1'b1);
        fill_d       = (fill_q == FILL_MAX) ? fill_q : ADDR_WIDTH'(fill_q + 1'b1);
        state_d      = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;

endmodule
